// File: rtl/fpu_norm_pkg.sv
// Shared types and defaults for the post-add normaliser and its leading-zero counter.
package fpu_norm_pkg;

  localparam int MANT_W_DEF = 23;
  localparam int EXP_W_DEF  = 8;
  localparam int EXP_MAX    = (1 << EXP_W_DEF) - 1;

  typedef struct packed {
    logic sticky;
    logic zero;
    logic ovf;
    logic unf;
  } norm_flags_t;

  // Per-beat control decoded in stage 1 so stage 2 only has to pick a path.
  typedef struct packed {
    logic enable;
    logic carry;
    logic zero;
  } s1_t;

  function automatic int expMaxOf(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/fpu_norm_pipe_if.sv
// Stream interface between the mantissa ALU, the normaliser and the rounding stage.
interface fpu_norm_pipe_if #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_enable;
  logic [MANT_W+1:0] in_mant;
  logic [EXP_W-1:0]  in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MANT_W:0]   out_mant;
  logic [EXP_W-1:0]  out_exp;
  logic              out_sticky;
  logic              out_zero;
  logic              out_ovf;
  logic              out_unf;

  modport master (
    output in_valid, in_enable, in_mant, in_exp, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_sticky, out_zero, out_ovf, out_unf
  );

  modport slave (
    input  in_valid, in_enable, in_mant, in_exp, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_sticky, out_zero, out_ovf, out_unf
  );
endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter built as a binary tree; count is W when the input is all zero.
module fpu_lzc #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data_i,
  output logic [CW-1:0] count_o,
  output logic          all_zero_o
);

  localparam int L = (W > 1) ? $clog2(W) : 1;
  localparam int P = 1 << L;

  logic [P-1:0] padded;
  logic         vld [L+1][P];
  logic [L-1:0] cnt [L+1][P];

  // Each node keeps "has a one" plus the zero count within its span; the MSB child wins.
  always_comb begin
    padded = '0;
    padded[P-1 -: W] = data_i;
    for (int l = 0; l <= L; l++) begin
      for (int n = 0; n < P; n++) begin
        vld[l][n] = 1'b0;
        cnt[l][n] = '0;
      end
    end
    for (int n = 0; n < P; n++) begin
      vld[0][n] = padded[n];
    end
    for (int l = 0; l < L; l++) begin
      for (int n = 0; n < (P >> (l + 1)); n++) begin
        vld[l+1][n] = vld[l][2*n+1] | vld[l][2*n];
        cnt[l+1][n] = vld[l][2*n+1] ? cnt[l][2*n+1] : (cnt[l][2*n] | (L'(1) << l));
      end
    end
  end

  assign all_zero_o = ~|data_i;
  assign count_o    = all_zero_o ? CW'(W) : CW'(cnt[L][0]);

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage post-add normaliser: stage 1 captures operands and leading-zero count,
// stage 2 shifts, adjusts the exponent and raises zero/overflow/underflow flags.
module fpu_norm_pipe
  import fpu_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input logic           clk,
  input logic           rst,
  fpu_norm_pipe_if.slave bus
);

  localparam int LZW = MANT_W + 1;
  localparam int CW  = $clog2(LZW + 1);
  localparam logic [EXP_W:0] EXP_LIMIT = (EXP_W + 1)'(expMaxOf(EXP_W));
  localparam logic [EXP_W:0] EXP_ONE   = (EXP_W + 1)'(1);

  logic [CW-1:0] lz_count;
  logic          lz_all_zero;

  logic              s1_valid_q;
  s1_t               s1_ctrl_q;
  logic [MANT_W+1:0] s1_mant_q;
  logic [EXP_W-1:0]  s1_exp_q;
  logic [CW-1:0]     s1_lz_q;

  logic              s2_valid_q;
  logic [MANT_W:0]   mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  norm_flags_t       flags_q, flags_d;

  logic             s1_adv, s2_adv;
  logic [EXP_W:0]   e_ext, e1, lz_ext, shift_amt;

  fpu_lzc #(.W(LZW), .CW(CW)) u_lzc (
    .data_i     (bus.in_mant[MANT_W:0]),
    .count_o    (lz_count),
    .all_zero_o (lz_all_zero)
  );

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = !s1_valid_q || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ctrl_q  <= '0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_lz_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ctrl_q.enable <= bus.in_enable;
        s1_ctrl_q.carry  <= bus.in_mant[MANT_W+1];
        s1_ctrl_q.zero   <= lz_all_zero && !bus.in_mant[MANT_W+1];
        s1_mant_q        <= bus.in_mant;
        s1_exp_q         <= bus.in_exp;
        s1_lz_q          <= lz_count;
      end
    end
  end

  // Exponent maths is one bit wider than the field so carry-increment and compare never wrap.
  always_comb begin
    e_ext     = {1'b0, s1_exp_q};
    e1        = e_ext + EXP_ONE;
    lz_ext    = (EXP_W + 1)'(s1_lz_q);
    shift_amt = '0;
    mant_d    = s1_mant_q[MANT_W:0];
    exp_d     = s1_exp_q;
    flags_d   = '0;
    if (!s1_ctrl_q.enable) begin
      mant_d = s1_mant_q[MANT_W:0];
    end else if (s1_ctrl_q.zero) begin
      mant_d       = '0;
      exp_d        = '0;
      flags_d.zero = 1'b1;
    end else if (s1_ctrl_q.carry) begin
      flags_d.sticky = s1_mant_q[0];
      if (e1 >= EXP_LIMIT) begin
        flags_d.ovf = 1'b1;
        exp_d       = '1;
        mant_d      = '0;
      end else begin
        mant_d = s1_mant_q[MANT_W+1:1];
        exp_d  = e1[EXP_W-1:0];
      end
    end else if (lz_ext != '0) begin
      if (e_ext > lz_ext) begin
        shift_amt = lz_ext;
        exp_d     = EXP_W'(e_ext - lz_ext);
      end else begin
        shift_amt   = (e_ext == '0) ? '0 : e_ext - EXP_ONE;
        exp_d       = '0;
        flags_d.unf = 1'b1;
      end
      mant_d = s1_mant_q[MANT_W:0] << shift_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      mant_q     <= '0;
      exp_q      <= '0;
      flags_q    <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        mant_q  <= mant_d;
        exp_q   <= exp_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_mant   = mant_q;
  assign bus.out_exp    = exp_q;
  assign bus.out_sticky = flags_q.sticky;
  assign bus.out_zero   = flags_q.zero;
  assign bus.out_ovf    = flags_q.ovf;
  assign bus.out_unf    = flags_q.unf;

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Directed bench for fpu_norm_pipe at MANT_W=23, EXP_W=8 with hand-computed expectations.
module tb_fpu_norm_pipe;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  fpu_norm_pipe_if #(.MANT_W(23), .EXP_W(8)) bus ();

  fpu_norm_pipe #(.MANT_W(23), .EXP_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Caller is positioned just after a falling edge; returns just after the next falling edge.
  task automatic applyStimulus(input logic en, input logic [24:0] m, input logic [7:0] e);
    int budget;
    budget = 0;
    bus.in_valid  = 1'b1;
    bus.in_enable = en;
    bus.in_mant   = m;
    bus.in_exp    = e;
    #1;
    while (!bus.in_ready && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready) begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout: observed in_ready=%b expected 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [23:0] m, input logic [7:0] e,
                             input logic [3:0] flags);
    int budget;
    budget = 0;
    while (!bus.out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.out_valid) begin
      compared++;
      mismatched++;
      $error("FAIL %s_timeout: observed out_valid=0 expected 1", tag);
    end else begin
      checkValue({tag, "_mant"}, 32'(bus.out_mant), 32'(m));
      checkValue({tag, "_exp"}, 32'(bus.out_exp), 32'(e));
      checkValue({tag, "_flags"},
                 32'({bus.out_sticky, bus.out_zero, bus.out_ovf, bus.out_unf}), 32'(flags));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [24:0] bpMant [4];
  logic [7:0]  bpExp  [4];
  logic        bpEn   [4];
  logic [23:0] bpOutMant [4];
  logic [7:0]  bpOutExp  [4];
  int          sent;
  int          got;

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_enable = 1'b0;
    bus.in_mant   = '0;
    bus.in_exp    = '0;
    bus.out_ready = 1'b1;

    bpMant    = '{25'h0C00000, 25'h0000005, 25'h1234567, 25'h1FFFFFE};
    bpExp     = '{8'd100, 8'd100, 8'd7, 8'd10};
    bpEn      = '{1'b1, 1'b1, 1'b0, 1'b1};
    bpOutMant = '{24'hC00000, 24'hA00000, 24'h234567, 24'hFFFFFF};
    bpOutExp  = '{8'd100, 8'd79, 8'd7, 8'd11};

    repeat (2) @(negedge clk);
    checkValue("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkValue("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("rst_out_mant", 32'(bus.out_mant), 32'd0);
    checkValue("rst_flags", 32'({bus.out_sticky, bus.out_zero, bus.out_ovf, bus.out_unf}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b1, 25'h1000001, 8'd127);
    checkValue("latency_not_early", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    checkValue("latency_two", 32'(bus.out_valid), 32'd1);
    checkOutput("carry", 24'h800000, 8'd128, 4'b1000);

    applyStimulus(1'b1, 25'h0000100, 8'd127);
    checkOutput("shift15", 24'h800000, 8'd112, 4'b0000);

    applyStimulus(1'b1, 25'h0000000, 8'd77);
    checkOutput("zero", 24'h000000, 8'd0, 4'b0100);

    applyStimulus(1'b0, 25'h0000100, 8'd9);
    checkOutput("bypass", 24'h000100, 8'd9, 4'b0000);

    applyStimulus(1'b1, 25'h1000000, 8'd254);
    checkOutput("ovf", 24'h000000, 8'hFF, 4'b0010);

    applyStimulus(1'b1, 25'h1000000, 8'd253);
    checkOutput("ovf_edge", 24'h800000, 8'd254, 4'b0000);

    applyStimulus(1'b1, 25'h0000100, 8'd5);
    checkOutput("unf", 24'h001000, 8'd0, 4'b0001);

    applyStimulus(1'b1, 25'h0000100, 8'd15);
    checkOutput("unf_exp_eq_lz", 24'h400000, 8'd0, 4'b0001);

    applyStimulus(1'b1, 25'h0000100, 8'd16);
    checkOutput("exp_lz_plus1", 24'h800000, 8'd1, 4'b0000);

    applyStimulus(1'b1, 25'h0000100, 8'd0);
    checkOutput("unf_exp0", 24'h000100, 8'd0, 4'b0001);

    applyStimulus(1'b1, 25'h0800000, 8'd0);
    checkOutput("lz0_nochange", 24'h800000, 8'd0, 4'b0000);

    // Backpressure: downstream stalls for three cycles while four beats are offered back-to-back.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (sent < 4);
      if (sent < 4) begin
        bus.in_enable = bpEn[sent];
        bus.in_mant   = bpMant[sent];
        bus.in_exp    = bpExp[sent];
      end
      #1;
      if (cyc == 2) begin
        checkValue("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
      end
      if (cyc >= 2 && cyc < 5) begin
        checkValue($sformatf("bp_hold%0d", cyc), 32'({bus.out_valid, bus.out_mant}),
                   32'({1'b1, bpOutMant[0]}));
      end
      if (bus.out_valid && bus.out_ready) begin
        checkValue($sformatf("bp%0d_mant", got), 32'(bus.out_mant), 32'(bpOutMant[got]));
        checkValue($sformatf("bp%0d_exp", got), 32'(bus.out_exp), 32'(bpOutExp[got]));
        got++;
      end
      @(posedge clk);
      if (bus.in_valid && bus.in_ready) sent++;
      @(negedge clk);
      bus.in_valid = (sent < 4) ? bus.in_valid : 1'b0;
    end
    bus.in_valid = 1'b0;
    checkValue("bp_count", 32'(got), 32'd4);
    repeat (3) @(negedge clk);
    checkValue("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with both stages occupied must flush everything.
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 25'h1000001, 8'd127);
    applyStimulus(1'b1, 25'h0000100, 8'd127);
    #1;
    checkValue("full_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkValue("flush_out_valid", 32'(bus.out_valid), 32'd0);
    checkValue("flush_in_ready", 32'(bus.in_ready), 32'd1);
    checkValue("flush_out_mant", 32'(bus.out_mant), 32'd0);
    checkValue("flush_out_exp", 32'(bus.out_exp), 32'd0);
    checkValue("flush_flags", 32'({bus.out_sticky, bus.out_zero, bus.out_ovf, bus.out_unf}), 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("flush_lost", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
